pmm_top: RTL and testbench

//  Payload pattern-matching engine. Scans packet payload one byte per cycle against 4 fixed 4-byte patterns.

---
 rtl/pmm_top.sv | 246 ++++++++++++++++++++++++
 tb/tb_pmm_top.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pmm_top.sv
// Payload pattern matcher: 4 fixed 4-byte patterns (2 case-sensitive, 2 ASCII nocase) over a sliding byte window.
// Latency: one cycle from the accepted byte edge to its match result, trigger and EOP shift.
// Backpressure: none; a byte is consumed on every cycle payload_valid is high, with no ready signal.
module pmm_top #(
    parameter logic [31:0] PAT0      = 32'h47455420,
    parameter logic [31:0] PAT1      = 32'h726F6F74,
    parameter logic [31:0] PAT2      = 32'h636D642E,
    parameter logic [31:0] PAT3      = 32'h2F657463,
    parameter logic [10:0] RULE_BASE = 11'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  payload_in,
    input  logic        payload_valid,
    input  logic        start_of_packet,
    input  logic        end_of_packet,
    input  logic        enable_32byte_process,
    output logic        filter_trigger,
    output logic [10:0] rule_id,
    output logic        end_of_packet_shift,
    output logic [10:0] input_pmm_debug,
    output logic [12:0] output_pmm_debug,
    output logic [29:0] static_engine_debug,
    output logic [16:0] pcre_engine_debug,
    output logic [11:0] index,
    output logic [11:0] index_nocase,
    output logic [13:0] patternID,
    output logic [10:0] clk_counter,
    output logic [10:0] index_counter,
    output logic [51:0] debug_matching,
    output logic        state
);

    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_IN_PACKET = 1'b1;

    localparam logic [2:0]  FILL_FULL   = 3'd4;
    localparam logic [10:0] OFFSET_MAX  = 11'h7FF;
    localparam logic [10:0] WINDOW_LIM  = 11'd32;
    localparam logic [15:0] COUNT_MAX   = 16'hFFFF;

    // ASCII A-Z folded to a-z; every other byte passes through untouched.
    function automatic logic [7:0] to_lower(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5A) begin
            return c + 8'h20;
        end
        return c;
    endfunction

    function automatic logic [31:0] lower_word(input logic [31:0] w);
        return {to_lower(w[31:24]), to_lower(w[23:16]), to_lower(w[15:8]), to_lower(w[7:0])};
    endfunction

    // Registered state
    logic [0:0]  state_q;
    logic [31:0] window_q;
    logic [2:0]  fill_q;
    logic [10:0] offset_q;
    logic [10:0] clk_cnt_q;
    logic [15:0] match_cnt_q;
    logic        any_hit_q;
    logic [10:0] rule_id_q;
    logic        trig_q;
    logic        eop_shift_q;
    logic [11:0] index_q;
    logic [11:0] index_nocase_q;
    logic [13:0] pattern_id_q;
    logic [3:0]  hit_vec_q;
    logic [10:0] in_dbg_q;

    // Byte acceptance: a packet only opens on SOP, so stray bytes while idle are ignored
    logic accept;
    logic sop_acc;
    logic eop_acc;

    assign accept  = payload_valid & (start_of_packet | (state_q == ST_IN_PACKET));
    assign sop_acc = accept & start_of_packet;
    assign eop_acc = accept & end_of_packet;

    // Next window / fill / offset values; matching looks at these so results land one cycle after the byte
    logic [31:0] window_next;
    logic [2:0]  fill_next;
    logic [10:0] offset_next;
    logic [0:0]  state_next;

    // Window shift, fill saturation and offset saturation for the incoming byte
    always_comb begin
        window_next = window_q;
        fill_next   = fill_q;
        offset_next = offset_q;
        if (sop_acc) begin
            // SOP discards the previous packet's bytes so nothing matches across the boundary
            window_next = {24'h0, payload_in};
            fill_next   = 3'd1;
            offset_next = 11'd0;
        end else if (accept) begin
            window_next = {window_q[23:0], payload_in};
            fill_next   = (fill_q >= FILL_FULL) ? FILL_FULL : fill_q + 3'd1;
            offset_next = (offset_q == OFFSET_MAX) ? offset_q : offset_q + 11'd1;
        end
    end

    // Packet FSM: EOP wins over SOP so a single-byte packet leaves us idle
    always_comb begin
        state_next = state_q;
        if (accept) begin
            state_next = end_of_packet ? ST_IDLE : ST_IN_PACKET;
        end
    end

    // Pattern compare on the next window
    logic [31:0] window_lc;
    logic [3:0]  raw_hit;
    logic        gate_off;
    logic        eval_ok;
    logic [3:0]  hit_vec;
    logic        any_hit;
    logic        cs_hit;
    logic        nc_hit;

    assign window_lc  = lower_word(window_next);
    assign raw_hit[0] = (window_next == PAT0);
    assign raw_hit[1] = (window_next == PAT1);
    assign raw_hit[2] = (window_lc == PAT2);
    assign raw_hit[3] = (window_lc == PAT3);

    // In 32-byte mode only packet offsets 0..31 may produce hits
    assign gate_off = enable_32byte_process & (offset_next >= WINDOW_LIM);
    assign eval_ok  = accept & (fill_next == FILL_FULL) & ~gate_off;
    assign hit_vec  = eval_ok ? raw_hit : 4'b0000;
    assign any_hit  = |hit_vec;
    assign cs_hit   = |hit_vec[1:0];
    assign nc_hit   = |hit_vec[3:2];

    // Lowest-index hit decides the reported rule when several patterns fire together
    logic [1:0]  lowest_k;
    logic [10:0] rule_next;

    // Priority encode the hit vector, bit 0 first
    always_comb begin
        lowest_k = 2'd0;
        if (hit_vec[0]) begin
            lowest_k = 2'd0;
        end else if (hit_vec[1]) begin
            lowest_k = 2'd1;
        end else if (hit_vec[2]) begin
            lowest_k = 2'd2;
        end else if (hit_vec[3]) begin
            lowest_k = 2'd3;
        end
    end

    assign rule_next = RULE_BASE + {9'd0, lowest_k};

    // Packet tracking: FSM, byte window, fill level and byte offset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            window_q <= 32'h0;
            fill_q   <= 3'd0;
            offset_q <= 11'd0;
        end else begin
            state_q  <= state_next;
            window_q <= window_next;
            fill_q   <= fill_next;
            offset_q <= offset_next;
        end
    end

    // Free-running cycle counter, wraps at 11 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt_q <= 11'd0;
        end else begin
            clk_cnt_q <= clk_cnt_q + 11'd1;
        end
    end

    // One-cycle pulses: trigger on any hit, EOP shifted to line up with the last byte's result
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_q      <= 1'b0;
            eop_shift_q <= 1'b0;
            hit_vec_q   <= 4'b0000;
        end else begin
            trig_q      <= any_hit;
            eop_shift_q <= eop_acc;
            hit_vec_q   <= hit_vec;
        end
    end

    // Per-packet match results: rule, hit statistics and hit offsets; SOP clears them
    always_ff @(posedge clk) begin
        if (rst) begin
            rule_id_q      <= 11'd0;
            match_cnt_q    <= 16'd0;
            any_hit_q      <= 1'b0;
            index_q        <= 12'd0;
            index_nocase_q <= 12'd0;
            pattern_id_q   <= 14'd0;
        end else if (sop_acc) begin
            // No hit is possible on the SOP byte itself (fill is only 1)
            rule_id_q          <= 11'd0;
            match_cnt_q        <= 16'd0;
            any_hit_q          <= 1'b0;
            index_q[11]        <= 1'b0;
            index_nocase_q[11] <= 1'b0;
        end else if (any_hit) begin
            rule_id_q    <= rule_next;
            match_cnt_q  <= (match_cnt_q == COUNT_MAX) ? match_cnt_q : match_cnt_q + 16'd1;
            any_hit_q    <= 1'b1;
            pattern_id_q <= {hit_vec, offset_next[9:0]};
            if (cs_hit) begin
                index_q <= {1'b1, offset_next};
            end
            if (nc_hit) begin
                index_nocase_q <= {1'b1, offset_next};
            end
        end
    end

    // Raw input snapshot for the debug bus
    always_ff @(posedge clk) begin
        if (rst) begin
            in_dbg_q <= 11'd0;
        end else begin
            in_dbg_q <= {payload_valid, start_of_packet, end_of_packet, payload_in};
        end
    end

    assign filter_trigger      = trig_q;
    assign rule_id             = rule_id_q;
    assign end_of_packet_shift = eop_shift_q;
    assign input_pmm_debug     = in_dbg_q;
    assign output_pmm_debug    = {trig_q, eop_shift_q, rule_id_q};
    assign static_engine_debug = {hit_vec_q, window_q[23:0], state_q, enable_32byte_process};
    assign pcre_engine_debug   = {any_hit_q, match_cnt_q};
    assign index               = index_q;
    assign index_nocase        = index_nocase_q;
    assign patternID           = pattern_id_q;
    assign clk_counter         = clk_cnt_q;
    assign index_counter       = offset_q;
    assign debug_matching      = {window_q, hit_vec_q, fill_q, offset_q, state_q, 1'b0};
    assign state               = state_q;

endmodule

// File: tb/tb_pmm_top.sv
// Scoreboard bench for pmm_top: expected trigger/EOP events are queued by stimulus, popped by a monitor.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// Every event the DUT presents must match the head of the queue; the queue must drain by the end.
module tb_pmm_top;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  payload_in;
    logic        payload_valid;
    logic        start_of_packet;
    logic        end_of_packet;
    logic        enable_32byte_process;
    logic        filter_trigger;
    logic [10:0] rule_id;
    logic        end_of_packet_shift;
    logic [10:0] input_pmm_debug;
    logic [12:0] output_pmm_debug;
    logic [29:0] static_engine_debug;
    logic [16:0] pcre_engine_debug;
    logic [11:0] index;
    logic [11:0] index_nocase;
    logic [13:0] patternID;
    logic [10:0] clk_counter;
    logic [10:0] index_counter;
    logic [51:0] debug_matching;
    logic        state;

    always #5 clk = ~clk;

    pmm_top dut (
        .clk                   (clk),
        .rst                   (rst),
        .payload_in            (payload_in),
        .payload_valid         (payload_valid),
        .start_of_packet       (start_of_packet),
        .end_of_packet         (end_of_packet),
        .enable_32byte_process (enable_32byte_process),
        .filter_trigger        (filter_trigger),
        .rule_id               (rule_id),
        .end_of_packet_shift   (end_of_packet_shift),
        .input_pmm_debug       (input_pmm_debug),
        .output_pmm_debug      (output_pmm_debug),
        .static_engine_debug   (static_engine_debug),
        .pcre_engine_debug     (pcre_engine_debug),
        .index                 (index),
        .index_nocase          (index_nocase),
        .patternID             (patternID),
        .clk_counter           (clk_counter),
        .index_counter         (index_counter),
        .debug_matching        (debug_matching),
        .state                 (state)
    );

    typedef struct packed {
        logic        trig;
        logic        eop;
        logic [10:0] rule;
        logic [11:0] idx;
        logic [11:0] idxn;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic ev_t mk(input logic t, input logic e, input logic [10:0] r,
                               input logic [11:0] i, input logic [11:0] n);
        ev_t v;
        v.trig = t;
        v.eop  = e;
        v.rule = r;
        v.idx  = i;
        v.idxn = n;
        return v;
    endfunction

    // Monitor: any cycle with a trigger or EOP pulse is an event to be scored.
    // Index offsets are only compared when the expected valid bit is set.
    always @(negedge clk) begin
        if (!rst && (filter_trigger || end_of_packet_shift)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: trig=%0b eop=%0b rule=%0d, expected no event",
                         filter_trigger, end_of_packet_shift, rule_id);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("ev_trigger", 64'(filter_trigger), 64'(e.trig));
                check("ev_eop_shift", 64'(end_of_packet_shift), 64'(e.eop));
                check("ev_rule_id", 64'(rule_id), 64'(e.rule));
                check("ev_index_vld", 64'(index[11]), 64'(e.idx[11]));
                if (e.idx[11]) check("ev_index", 64'(index), 64'(e.idx));
                check("ev_index_nocase_vld", 64'(index_nocase[11]), 64'(e.idxn[11]));
                if (e.idxn[11]) check("ev_index_nocase", 64'(index_nocase), 64'(e.idxn));
            end
        end
    end

    task automatic drive(input logic [7:0] b, input logic v, input logic s, input logic e);
        @(negedge clk);
        payload_in      = b;
        payload_valid   = v;
        start_of_packet = s;
        end_of_packet   = e;
    endtask

    task automatic send_pkt(input string s);
        for (int i = 0; i < s.len(); i++) begin
            drive(s[i], 1'b1, (i == 0), (i == s.len() - 1));
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // 44-byte packet of 'z' filler with "root" at offsets 40..43, EOP on the final 't'
    task automatic send_root_at40();
        logic [7:0] b;
        for (int i = 0; i < 44; i++) begin
            case (i)
                40:      b = 8'h72;
                41:      b = 8'h6F;
                42:      b = 8'h6F;
                43:      b = 8'h74;
                default: b = 8'h7A;
            endcase
            drive(b, 1'b1, (i == 0), (i == 43));
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst                   = 1'b1;
        payload_in            = 8'h00;
        payload_valid         = 1'b0;
        start_of_packet       = 1'b0;
        end_of_packet         = 1'b0;
        enable_32byte_process = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_trigger_rule", 64'({filter_trigger, rule_id, end_of_packet_shift}), 64'd0);
        check("rst_debug_io", 64'({input_pmm_debug, output_pmm_debug}), 64'd0);
        check("rst_static_dbg", 64'(static_engine_debug), 64'd0);
        check("rst_pcre_dbg", 64'(pcre_engine_debug), 64'd0);
        check("rst_indexes", 64'({index, index_nocase, patternID}), 64'd0);
        check("rst_counters", 64'({clk_counter, index_counter, state}), 64'd0);
        check("rst_debug_matching", debug_matching, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("clk_counter_1", 64'(clk_counter), 64'd1);
        @(negedge clk);
        check("clk_counter_2", 64'(clk_counter), 64'd2);
        enable_32byte_process = 1'b1;

        // "xGET a" with an idle gap mid-packet: hit at offset 4, EOP at offset 5
        exp_q.push_back(mk(1'b1, 1'b0, 11'd1, 12'h804, 12'h000));
        exp_q.push_back(mk(1'b0, 1'b1, 11'd1, 12'h804, 12'h000));
        drive("x", 1'b1, 1'b1, 1'b0);
        drive("G", 1'b1, 1'b0, 1'b0);
        drive("Q", 1'b0, 1'b0, 1'b0);
        drive("E", 1'b1, 1'b0, 1'b0);
        drive("T", 1'b1, 1'b0, 1'b0);
        drive(8'h20, 1'b1, 1'b0, 1'b0);
        drive("a", 1'b1, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        check("pkt1_state_idle", 64'(state), 64'd0);
        check("pkt1_patternID", 64'(patternID), 64'({4'b0001, 10'd4}));

        // Valid bytes while idle without SOP are ignored
        drive("G", 1'b1, 1'b0, 1'b0);
        drive("E", 1'b1, 1'b0, 1'b0);
        drive("T", 1'b1, 1'b0, 1'b0);
        drive(8'h20, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        check("idle_no_accept_offset", 64'(index_counter), 64'd5);
        check("idle_rule_held", 64'(rule_id), 64'd1);

        // "/ETC": nocase hit on the EOP byte
        exp_q.push_back(mk(1'b1, 1'b1, 11'd4, 12'h000, 12'h803));
        send_pkt("/ETC");

        // "GeT ": case-sensitive miss; SOP cleared rule_id
        exp_q.push_back(mk(1'b0, 1'b1, 11'd0, 12'h000, 12'h000));
        send_pkt("GeT ");

        // "root" at offsets 40..43, gated by 32-byte mode
        exp_q.push_back(mk(1'b0, 1'b1, 11'd0, 12'h000, 12'h000));
        send_root_at40();

        // Same packet, gating off
        enable_32byte_process = 1'b0;
        exp_q.push_back(mk(1'b1, 1'b1, 11'd2, 12'h82B, 12'h000));
        send_root_at40();
        enable_32byte_process = 1'b1;

        // Packet ends "GE", next starts "T ": no match across SOP, rule_id cleared
        exp_q.push_back(mk(1'b1, 1'b0, 11'd1, 12'h803, 12'h000));
        exp_q.push_back(mk(1'b0, 1'b1, 11'd1, 12'h803, 12'h000));
        send_pkt("GET GE");
        exp_q.push_back(mk(1'b0, 1'b1, 11'd0, 12'h000, 12'h000));
        send_pkt("T x");

        // Two nocase hits in one packet; match count 2
        exp_q.push_back(mk(1'b1, 1'b0, 11'd3, 12'h000, 12'h803));
        exp_q.push_back(mk(1'b1, 1'b1, 11'd3, 12'h000, 12'h807));
        send_pkt("cmd.CMD.");
        check("pcre_count_2", 64'(pcre_engine_debug), 64'({1'b1, 16'd2}));
        check("patternID_nocase", 64'(patternID), 64'({4'b0100, 10'd7}));

        // Single-byte packet
        exp_q.push_back(mk(1'b0, 1'b1, 11'd0, 12'h000, 12'h000));
        send_pkt("Q");
        check("one_byte_state", 64'(state), 64'd0);
        check("one_byte_pcre_clear", 64'(pcre_engine_debug), 64'd0);

        // Reset mid-packet; follow-on bytes without SOP are not accepted
        drive("G", 1'b1, 1'b1, 1'b0);
        drive("E", 1'b1, 1'b0, 1'b0);
        check("midpkt_state_open", 64'(state), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        payload_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive("T", 1'b1, 1'b0, 1'b0);
        drive(8'h20, 1'b1, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        check("abort_state", 64'(state), 64'd0);
        check("abort_offset", 64'(index_counter), 64'd0);
        check("abort_window", 64'(debug_matching[51:20]), 64'd0);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
